// File: rtl/gift_cofb_pkg.sv
// Shared definitions for the GIFT-COFB key-schedule sequencer and its ISE datapath.
package gift_cofb_pkg;

    // One-hot ISE opcodes as seen on ise_op: {fs_keyupdate, keyarrange, keyupdate, swapmove}.
    localparam logic [3:0] OP_NONE        = 4'b0000;
    localparam logic [3:0] OP_SWAPMOVE    = 4'b0001;
    localparam logic [3:0] OP_KEYUPDATE   = 4'b0010;
    localparam logic [3:0] OP_KEYARRANGE  = 4'b0100;
    localparam logic [3:0] OP_FSKEYUPDATE = 4'b1000;

    // The fixsliced key update cycles through this many immediate pairs.
    localparam int FS_PERIOD = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARRANGE = 2'd1,
        UPDATE  = 2'd2,
        DONE    = 2'd3
    } ks_state_e;

endpackage

// File: rtl/gift_cofb_rk_skid.sv
// One-entry round-key output register with valid/ready handshake.
// A load takes priority over draining so that a word accepted in the same
// cycle as the next issue is replaced without a bubble.
module gift_cofb_rk_skid #(
    parameter int DW = 32,
    parameter int IW = 7
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [IW-1:0] load_idx,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [IW-1:0] idx
);

    // Hold the word until it is accepted; clear abandons it outright.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            idx   <= load_idx;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gift_cofb_ks_seq.sv
// Key-schedule sequencer: drives the combinational GIFT-COFB ISE unit one
// operation per cycle and streams the resulting round-key words downstream.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; counters held at zero
// ARRANGE | streaming keyarrange words 0..3 from the captured key
// UPDATE  | streaming key-update words 4..NW-1 from stA/stB
// DONE    | single-cycle done pulse, then back to IDLE
module gift_cofb_ks_seq
    import gift_cofb_pkg::*;
#(
    parameter int ROUNDS = 40,
    parameter int CNT_W  = 7
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [127:0]     key,
    output logic [3:0]       ise_op,
    output logic [4:0]       ise_imm,
    output logic [31:0]      ise_rs1,
    input  logic [31:0]      ise_rd,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [31:0]      rk_data,
    output logic [CNT_W-1:0] rk_idx,
    output logic             busy,
    output logic             done
);

    localparam int              NW     = 2 * ROUNDS;
    localparam logic [CNT_W-1:0] NW_C   = CNT_W'(NW);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] ARR_LAST_C = CNT_W'(3);
    localparam logic [2:0]       M_LAST_C   = 3'(FS_PERIOD - 1);

    ks_state_e        state_q, state_d;
    logic             mode_q;
    logic [31:0]      kbuf_q [4];
    logic [31:0]      st_a_q, st_b_q;
    logic [CNT_W-1:0] issued_q, accepted_q;
    logic [2:0]       m_q;

    logic in_run;
    logic issue;
    logic accept;
    logic clear;
    logic arrange_phase;

    assign in_run        = (state_q == ARRANGE) || (state_q == UPDATE);
    assign issue         = in_run && !abort && (!rk_valid || rk_ready) && (issued_q < NW_C);
    assign accept        = rk_valid && rk_ready;
    assign clear         = abort && (state_q != IDLE);
    // The op is chosen by issue index, not state: word 4 may issue while
    // word 3 is still being accepted in ARRANGE.
    assign arrange_phase = (issued_q < CNT_W'(4));

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start beats abort in IDLE, abort wins everywhere else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ARRANGE;
            end
            ARRANGE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && (accepted_q == ARR_LAST_C)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && (accepted_q == LAST_C)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ISE drive: opcode, immediate and operand for the word being issued.
    always_comb begin
        ise_op  = OP_NONE;
        ise_imm = '0;
        ise_rs1 = '0;
        if (issue) begin
            if (arrange_phase) begin
                ise_op  = OP_KEYARRANGE;
                ise_imm = {3'b000, issued_q[1:0]};
                ise_rs1 = kbuf_q[issued_q[1:0]];
            end else begin
                ise_rs1 = issued_q[0] ? st_b_q : st_a_q;
                if (mode_q) begin
                    ise_op = OP_KEYUPDATE;
                end else begin
                    ise_op  = OP_FSKEYUPDATE;
                    ise_imm = {1'b0, m_q, issued_q[0]};
                end
            end
        end
    end

    // Key capture, running key state and the issue/accept counters.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            mode_q     <= 1'b0;
            for (int k = 0; k < 4; k++) kbuf_q[k] <= '0;
            st_a_q     <= '0;
            st_b_q     <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            m_q        <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                mode_q <= mode;
                for (int k = 0; k < 4; k++) kbuf_q[k] <= key[32*k +: 32];
            end
            issued_q   <= '0;
            accepted_q <= '0;
            m_q        <= '0;
        end else if (abort || (state_q == DONE)) begin
            issued_q   <= '0;
            accepted_q <= '0;
            m_q        <= '0;
        end else begin
            if (issue) begin
                issued_q <= issued_q + 1'b1;
                // Words 2/3 seed the even/odd update chains; later words advance them.
                if (issued_q >= CNT_W'(2)) begin
                    if (issued_q[0]) st_b_q <= ise_rd;
                    else             st_a_q <= ise_rd;
                end
                if (!arrange_phase && issued_q[0]) begin
                    m_q <= (m_q == M_LAST_C) ? 3'd0 : m_q + 3'd1;
                end
            end
            if (accept && (accepted_q < NW_C)) begin
                accepted_q <= accepted_q + 1'b1;
            end
        end
    end

    gift_cofb_rk_skid #(
        .DW (32),
        .IW (CNT_W)
    ) u_rk_skid (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .clear     (clear),
        .load      (issue),
        .load_data (ise_rd),
        .load_idx  (issued_q),
        .ready     (rk_ready),
        .valid     (rk_valid),
        .data      (rk_data),
        .idx       (rk_idx)
    );

endmodule

// File: tb/tb_gift_cofb_ks_seq.sv
// Bench for the key-schedule sequencer: a stand-in ISE drives ise_rd and a
// word-level key-schedule model predicts ops, operands and the output stream.
module tb_gift_cofb_ks_seq;

    localparam int ROUNDS = 40;
    localparam int CNT_W  = 7;
    localparam int NW     = 2 * ROUNDS;

    localparam logic [3:0] OPC_UPD = 4'b0010;
    localparam logic [3:0] OPC_ARR = 4'b0100;
    localparam logic [3:0] OPC_FS  = 4'b1000;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;

    logic             g_clk = 1'b0;
    logic             g_resetn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mode = 1'b0;
    logic [127:0]     key = '0;
    logic [3:0]       ise_op;
    logic [4:0]       ise_imm;
    logic [31:0]      ise_rs1;
    logic [31:0]      ise_rd;
    logic             rk_valid;
    logic             rk_ready = 1'b1;
    logic [31:0]      rk_data;
    logic [CNT_W-1:0] rk_idx;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w   [NW];
    logic [31:0] exp_rs1 [NW];
    logic [3:0]  exp_op  [NW];
    logic [4:0]  exp_imm [NW];

    always #5 g_clk = ~g_clk;

    gift_cofb_ks_seq #(
        .ROUNDS (ROUNDS),
        .CNT_W  (CNT_W)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .key      (key),
        .ise_op   (ise_op),
        .ise_imm  (ise_imm),
        .ise_rs1  (ise_rs1),
        .ise_rd   (ise_rd),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Stand-in ISE: distinct, immediate-sensitive function per opcode.
    function automatic logic [31:0] ise_fn(input logic [3:0] op, input logic [4:0] imm,
                                           input logic [31:0] x);
        case (op)
            OPC_ARR: return rotl(x, int'(imm) + 1) ^ (32'h9E3779B9 * (32'(imm) + 32'd1));
            OPC_UPD: return {x[17:16], x[31:18], x[11:0], x[15:12]};
            OPC_FS:  return rotl(x, int'(imm) + 3) ^ (32'h01000193 * 32'(imm)) ^ 32'h5A5A0000;
            default: return 32'h0;
        endcase
    endfunction

    assign ise_rd = ise_fn(ise_op, ise_imm, ise_rs1);

    // Word-level schedule: four arranged key words, then two interleaved
    // update chains, each word feeding the word two positions later.
    task automatic build_model(input logic m, input logic [127:0] k);
        for (int i = 0; i < NW; i++) begin
            if (i < 4) begin
                exp_op[i]  = OPC_ARR;
                exp_imm[i] = 5'(i);
                exp_rs1[i] = k[32*i +: 32];
            end else begin
                exp_op[i]  = m ? OPC_UPD : OPC_FS;
                exp_imm[i] = m ? 5'd0 : 5'((i - 4) % 10);
                exp_rs1[i] = exp_w[i-2];
            end
            exp_w[i] = ise_fn(exp_op[i], exp_imm[i], exp_rs1[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "/rk_valid"}, rk_valid, 0);
        chk({tag, "/rk_data"},  rk_data,  0);
        chk({tag, "/rk_idx"},   rk_idx,   0);
        chk({tag, "/busy"},     busy,     0);
        chk({tag, "/done"},     done,     0);
        chk({tag, "/ise_op"},   ise_op,   0);
        chk({tag, "/ise_imm"},  ise_imm,  0);
        chk({tag, "/ise_rs1"},  ise_rs1,  0);
    endtask

    // Called at posedge+1 with the DUT idle. Events trigger when the named
    // word is presented on the output (-1 disables them).
    task automatic run_case(input string name, input logic m, input logic [127:0] k,
                            input bit rnd, input int stall_word, input int stall_len,
                            input bit abort_in_stall, input int start_word, input int reset_word);
        int nacc = 0;
        int niss = 0;
        int stall_left = 0;
        int resume_cyc = -1;
        int last_acc = -10;
        int kind = 0;
        bit stalled = 0;
        bit restarted = 0;
        bit fin = 0;
        logic [31:0] hd = '0;
        logic [CNT_W-1:0] hi = '0;

        build_model(m, k);
        start = 1'b1; mode = m; key = k; rk_ready = 1'b1;
        @(posedge g_clk); #1;
        start = 1'b0; mode = ~m; key = rand_key();

        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (stall_word >= 0 && !stalled && rk_valid && int'(rk_idx) == stall_word) begin
                stalled = 1; stall_left = stall_len; hd = rk_data; hi = rk_idx;
            end
            if (stall_left > 0) rk_ready = 1'b0;
            else                rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            abort = abort_in_stall && (stall_left == 2);
            if (start_word >= 0 && !restarted && rk_valid && int'(rk_idx) == start_word) begin
                restarted = 1; start = 1'b1; key = ~k; mode = ~m;
            end else begin
                start = 1'b0;
            end

            if (reset_word >= 0 && rk_valid && int'(rk_idx) == reset_word) begin
                #1 g_resetn = 1'b0;
                #1 chk_all_zero({name, "/async_rst"});
                @(negedge g_clk); g_resetn = 1'b1;
                @(posedge g_clk); #1;
                fin = 1; kind = 2;
            end else begin
                @(negedge g_clk);
                if (cyc == 0) chk({name, "/busy"}, busy, 1);
                if (ise_op != 4'b0) begin
                    if (niss < NW) begin
                        chk({name, "/op"},  ise_op,  exp_op[niss]);
                        chk({name, "/imm"}, ise_imm, exp_imm[niss]);
                        chk({name, "/rs1"}, ise_rs1, exp_rs1[niss]);
                    end else begin
                        chk({name, "/extra_issue"}, niss, NW - 1);
                    end
                    niss++;
                end
                if (rk_valid && rk_ready) begin
                    if (nacc < NW) begin
                        chk({name, "/idx"},  rk_idx,  nacc);
                        chk({name, "/data"}, rk_data, exp_w[nacc]);
                    end else begin
                        chk({name, "/extra_word"}, nacc, NW - 1);
                    end
                    nacc++;
                    last_acc = cyc;
                end
                if (!rnd && cyc == resume_cyc) begin
                    chk({name, "/resume_valid"}, rk_valid, 1);
                    chk({name, "/resume_idx"},   rk_idx,   hi + 1'b1);
                end
                if (stall_left > 0) begin
                    chk({name, "/stall_data"},  rk_data,  hd);
                    chk({name, "/stall_idx"},   rk_idx,   hi);
                    chk({name, "/stall_valid"}, rk_valid, 1);
                    chk({name, "/stall_op"},    ise_op,   0);
                    stall_left--;
                    if (stall_left == 0) resume_cyc = cyc + 2;
                end
                if (done) begin
                    chk({name, "/done_count"}, nacc, NW);
                    chk({name, "/done_timing"}, cyc, last_acc + 1);
                    fin = 1;
                end
                if (abort) begin
                    chk({name, "/abort_op"}, ise_op, 0);
                    @(posedge g_clk); #1;
                    abort = 1'b0; rk_ready = 1'b1;
                    @(negedge g_clk);
                    chk({name, "/abort_busy"},  busy,     0);
                    chk({name, "/abort_valid"}, rk_valid, 0);
                    chk({name, "/abort_done"},  done,     0);
                    fin = 1; kind = 1;
                end
                @(posedge g_clk); #1;
            end
        end

        abort = 1'b0; start = 1'b0; rk_ready = 1'b1;
        if (!fin) begin
            chk({name, "/timeout"}, 0, 1);
        end else if (kind == 0) begin
            chk({name, "/issue_count"}, niss, NW);
            @(negedge g_clk);
            chk({name, "/idle_busy"}, busy, 0);
            chk({name, "/idle_done"}, done, 0);
            @(posedge g_clk); #1;
        end
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        @(negedge g_clk); g_resetn = 1'b1;
        @(posedge g_clk); #1;

        run_case("m0_key0",     1'b0, KEY0,       0, -1, 0, 0, -1, -1);
        run_case("m1_key0",     1'b1, KEY0,       0, -1, 0, 0, -1, -1);
        run_case("stall10",     1'b0, KEY0,       0, 10, 5, 0, -1, -1);
        run_case("abort37",     1'b1, rand_key(), 0, 37, 5, 1, -1, -1);
        run_case("after_abort", 1'b0, rand_key(), 0, -1, 0, 0, -1, -1);
        run_case("start20",     1'b0, rand_key(), 0, -1, 0, 0, 20, -1);
        run_case("reset50",     1'b1, rand_key(), 0, -1, 0, 0, -1, 50);
        run_case("after_reset", 1'b0, rand_key(), 0, -1, 0, 0, -1, -1);
        for (int r = 0; r < 4; r++) begin
            run_case("rand_ready", r[0], rand_key(), 1, -1, 0, 0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gift_cofb_ks_seq.md
Name: gift_cofb_ks_seq

Overview:
- Sequencer that drives the GIFT-COFB key-schedule ISE datapath to expand one 128-bit key into a stream of 32-bit round-key words.
- The ISE datapath is a separate, purely combinational instance; this block drives its opcode, immediate and operand, then captures its result.
- Sits beside the ISE unit in the crypto coprocessor path. Its output stream feeds a round-key buffer.
- Exactly one ISE operation per cycle; downstream backpressure is supported.

Parameters:
- ROUNDS, 40, number of GIFT-128 rounds; total output words NW = 2*ROUNDS (must be even and >= 4).
- CNT_W, 7, width of the word counter; must satisfy 2^CNT_W > NW.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  asynchronous active-low reset.
- start  in  1  begin expansion; sampled only in IDLE.
- abort  in  1  cancel the current expansion; return to IDLE next cycle.
- mode  in  1  0 = fixsliced (fs_keyupdate); 1 = classic (keyupdate); sampled with start.
- key  in  128  key words w0..w3 = key[31:0]..key[127:96]; sampled with start.
- ise_op  out  4  one-hot {fs_keyupdate, keyarrange, keyupdate, swapmove}; 0 = no operation.
- ise_imm  out  5  immediate to the ISE.
- ise_rs1  out  32  operand to the ISE.
- ise_rd  in  32  ISE result, combinational from ise_op, ise_imm and ise_rs1.
- rk_valid  out  1  round-key word valid.
- rk_ready  in  1  downstream accepts the word.
- rk_data  out  32  round-key word.
- rk_idx  out  CNT_W  index of rk_data, counting 0..NW-1.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: state = IDLE; all outputs 0; all counters and registers 0.
- States and transitions:
  - IDLE -> ARRANGE on start; captures key into kbuf[0..3] and mode.
  - ARRANGE: issues k = 0..3.
  - ARRANGE -> UPDATE after word 3 is accepted.
  - UPDATE -> DONE after word NW-1 is accepted.
  - DONE lasts exactly one cycle with done = 1, then goes to IDLE.
- Issue rule: a new ISE op is issued in any ARRANGE/UPDATE cycle where the output register is empty or being accepted (rk_valid=0 or rk_ready=1) and words issued < NW. Otherwise ise_op = 0.
- Capture rule: ise_rd is captured into rk_data on the same clock edge as issue. rk_valid rises the next cycle and rk_idx = issue index. Issue-to-valid latency is 1 cycle.
- Throughput: one word per cycle with rk_ready held high.
- Stall rule: while rk_valid=1 and rk_ready=0, rk_data and rk_idx are held stable and no op is issued.
- ARRANGE word k (k = 0..3): ise_op = keyarrange, ise_imm = k, ise_rs1 = kbuf[k]. On capture of k=2 load stA; on capture of k=3 load stB.
- UPDATE, issue index i >= 4, even i: ise_rs1 = stA; stA <= ise_rd on issue.
- UPDATE, issue index i >= 4, odd i: ise_rs1 = stB; stB <= ise_rd on issue.
- UPDATE, mode 0:
  - ise_op = fs_keyupdate, ise_imm = 2*m + (i & 1).
  - m is a 0..4 counter that increments after each odd word and wraps from 4 to 0.
- UPDATE, mode 1: ise_op = keyupdate, ise_imm = 0.
- The swapmove op is never issued by this block.
- start while busy is ignored. mode and key changes while busy have no effect.
- abort in any non-IDLE state, including mid-stall:
  - Next state is IDLE; rk_valid <= 0; all counters cleared.
  - done is not pulsed, and no further ops are issued in the abort cycle.
- abort and start in the same cycle while IDLE: start wins.
- Counter wrap: the issued and accepted counters saturate at NW; rk_idx never exceeds NW-1.
- Asynchronous reset mid-expansion: all state returns to IDLE immediately; the partial stream is abandoned.

Decomposition:
- Shared package gift_cofb_pkg:
  - ISE op one-hot constants OP_SWAPMOVE, OP_KEYUPDATE, OP_KEYARRANGE, OP_FSKEYUPDATE.
  - State enum {IDLE, ARRANGE, UPDATE, DONE}.
  - Constant FS_PERIOD = 5.
- One natural sub-module: gift_cofb_rk_skid, the 1-entry output register with its valid/ready logic.
- The ISE instance is instantiated by the parent, not inside this block.

Test Plan:
- Mode 0, key = 128'h000102030405060708090A0B0C0D0E0F, rk_ready = 1:
  - Exactly 80 words with rk_idx 0..79; done pulses in the cycle after word 79 is accepted.
  - Imm sequence is 0,1,2,3, then 0,1,2,...,9 repeating.
  - Every word matches a software fixsliced key-schedule model.
- Mode 1, same key: ise_op = keyupdate for words 4..79; the stream matches the classic key-update model; stA/stB alternation is checked.
- Backpressure: hold rk_ready = 0 for 5 cycles at word 10.
  - rk_data/rk_idx stay stable and ise_op = 0 during the stall.
  - Word 11 appears 1 cycle after rk_ready returns to 1; no loss or duplication.
- Abort at word 37 during a stall:
  - busy = 0 and rk_valid = 0 the next cycle; no done pulse.
  - A fresh start then produces idx 0 again with the correct first word.
- Start pulsed at word 20 with a different key: ignored; the stream continues from the original key.
- g_resetn asserted at word 50: all outputs go to 0 asynchronously; a subsequent start gives a full, correct 80-word stream.
